serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  Bit-serial ripple adder. Each cycle it feeds one LSB-first bit pair of op_a/op_b
//  plus a registered carry into one full-adder cell; that cell's carry out becomes the
//  next cycle's carry in. Trades WIDTH cycles of latency for one full-adder cell.
//  Sits between the operand source (start/op_a/op_b) and the result consumer (done/sum/cout).
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//  clk    in   1      rising-edge clock, single clock domain
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request; sampled only when busy==0
//  op_a   in   WIDTH  operand A, captured on the accepted start edge
//  op_b   in   WIDTH  operand B, captured on the accepted start edge
//  cin    in   1      carry in, captured on the accepted start edge
//  busy   out  1      high while bits are being summed
//  done   out  1      one-cycle pulse; sum/cout are valid from this cycle
//  sum    out  WIDTH  result, held stable until the next done
//  cout   out  1      final carry, held stable with sum
// BEHAVIOUR
//  - Reset: one clock; rst is asynchronous, active-high. While rst=1: state=IDLE,
//    busy=0, done=0, sum=0, cout=0, and shift registers, carry and bit counter all 0.
//    Asserting rst mid-operation aborts the addition; the partial result is discarded.
//  - FSM states:
//    IDLE  -> SHIFT on start=1; captures op_a, op_b and cin, and clears the counter.
//    SHIFT -> one bit per edge:
//             s = a0^b0^c;  c <= a0&b0 | c&(a0^b0);
//             s enters the MSB of the partial-result register; both operands shift right.
//             The counter runs 0..WIDTH-1; on the edge where the count is WIDTH-1 the
//             FSM goes to DONE.
//    DONE  -> lasts exactly one cycle. Goes to SHIFT if start=1 that cycle (back-to-back
//             accept), otherwise to IDLE.
//  - busy = (state==SHIFT). done = (state==DONE). Both outputs are registered.
//  - Latency: start accepted at edge k; busy is high for the WIDTH cycles after edges
//    k..k+WIDTH-1; done is high for the cycle after edge k+WIDTH.
//    Throughput is one add per WIDTH+1 cycles.
//  - sum/cout load only on the edge that enters DONE. They do not change while
//    busy=1, and they hold through IDLE and through the next SHIFT.
//  - start is ignored while busy=1, and op_a/op_b/cin changes mid-operation have no
//    effect. start held high continuously gives repeated adds, with one DONE cycle
//    between them.
//  - Arithmetic is modulo 2^WIDTH: {cout,sum} = op_a + op_b + cin, with no overflow
//    flag. Overflow cases such as all-ones + 1 wrap to sum=0, cout=1.
// CONFIGURATION
//  SERIAL_SUB_EN
//   - Defined: adds input port sub (1 bit), captured with start. When sub=1 the block
//     shifts ~op_b and seeds the carry with 1 (cin is ignored), so sum = op_a - op_b
//     mod 2^WIDTH and cout = 1 means no borrow (op_a >= op_b unsigned). When sub=0 the
//     behaviour matches the undefined case.
//   - Undefined: no sub port; add only, exactly as above.
// TESTING  (WIDTH=8)
//  1. rst=1 with start=1 held -> busy=0, done=0, sum=0, cout=0 throughout; no state change.
//  2. start, op_a=8'h35, op_b=8'h4A, cin=0 -> busy for 8 cycles, then done one cycle
//     with sum=8'h7F, cout=0.
//  3. op_a=8'hFF, op_b=8'h00, cin=1 -> sum=8'h00, cout=1 (wrap). Then op_a=8'hFF,
//     op_b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  4. start pulsed again 3 cycles into an add, with new operands -> ignored; the first
//     result is unchanged and exactly one done pulse occurs. start held high ->
//     done pulses every 9 cycles.
//  5. rst asserted 4 cycles into an add of 8'h12+8'h34 -> IDLE and outputs zero
//     immediately; a following add of 8'h01+8'h01 gives sum=8'h02, cout=0.
//  6. [SERIAL_SUB_EN] sub=1: 8'h50-8'h20 -> sum=8'h30, cout=1; 8'h20-8'h50 ->
//     sum=8'hD0, cout=0.
//  Self-check every done against the reference {cout,sum}=op_a+op_b+cin (or the
//  subtract form). Also run 200 random operand sets. Confirm sum is stable while busy=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a registered carry, one bit pair per cycle.
// Optional feature: define SERIAL_SUB_EN to add a 'sub' port (sum = op_a - op_b, cout = no borrow).
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept_c;
    logic              last_c;
    logic              bit_s_c;
    logic              carry_nxt_c;
    logic [WIDTH-1:0]  b_load_c;
    logic              carry_load_c;

    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  acc;
    logic              carry;
    logic [CNT_W-1:0]  cnt;

    // Subtract is add of the inverted operand with the carry seeded to one.
`ifdef SERIAL_SUB_EN
    assign b_load_c     = sub ? ~op_b : op_b;
    assign carry_load_c = sub ? 1'b1 : cin;
`else
    assign b_load_c     = op_b;
    assign carry_load_c = cin;
`endif

    // The single full-adder cell.
    assign bit_s_c     = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_nxt_c = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    assign last_c      = (cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; a new request is taken from IDLE or back-to-back from DONE.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_c) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    accept_c  = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, bit-serial datapath and result load on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept_c) begin
            a_sr  <= op_a;
            b_sr  <= b_load_c;
            carry <= carry_load_c;
            acc   <= '0;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            carry <= carry_nxt_c;
            acc   <= {bit_s_c, acc[WIDTH-1:1]};
            cnt   <= cnt + CNT_W'(1);
            if (last_c) begin
                sum  <= {bit_s_c, acc[WIDTH-1:1]};
                cout <= carry_nxt_c;
            end
        end
    end

    // Registered status flags track the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == SHIFT);
            done <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (WIDTH=8) against an arithmetic model.
module tb_serial_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] held_sum;
    logic         held_cout;
    logic [W-1:0] exp_sum;
    logic         exp_cout;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
`ifdef SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a request and compute its expected result from plain arithmetic.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic s);
        logic [W:0] r;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
`ifdef SERIAL_SUB_EN
        if (s) r = {(a >= b), W'(a - b)};
        else   r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`else
        r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
`endif
        exp_sum  = r[W-1:0];
        exp_cout = r[W];
    endtask

    // Called at the negedge where start is presented; checks the busy window and done cycle.
    // mode 0: start dropped, operands scrambled, a stray start pulse 3 cycles in.
    // mode 1: start left high (back-to-back stream).
    task automatic wait_result(input int mode);
        for (int i = 0; i < int'(W); i++) begin
            @(negedge clk);
            chk("busy_hi", 32'(busy), 32'd1);
            chk("done_lo", 32'(done), 32'd0);
            chk("sum_hold", 32'(sum), 32'(held_sum));
            chk("cout_hold", 32'(cout), 32'(held_cout));
            if (mode == 0) begin
                start = (i == 2);
                op_a  = W'($urandom);
                op_b  = W'($urandom);
                cin   = 1'($urandom);
                sub   = 1'($urandom);
            end
            if (i == int'(W) - 1 && mode == 0) start = 1'b0;
        end
        @(negedge clk);
        chk("done_hi", 32'(done), 32'd1);
        chk("busy_lo", 32'(busy), 32'd0);
        chk("sum", 32'(sum), 32'(exp_sum));
        chk("cout", 32'(cout), 32'(exp_cout));
        held_sum  = exp_sum;
        held_cout = exp_cout;
    endtask

    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic s);
        drive_start(a, b, c, s);
        wait_result(0);
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_sum", 32'(sum), 32'(held_sum));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        op_a  = 8'hA5;
        op_b  = 8'h5A;
        cin   = 1'b1;
        sub   = 1'b0;
        held_sum  = '0;
        held_cout = 1'b0;
        exp_sum   = '0;
        exp_cout  = 1'b0;

        // Reset held with start high: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_cout", 32'(cout), 32'd0);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Directed cases, including wrap-around.
        run_add(8'h35, 8'h4A, 1'b0, 1'b0);
        run_add(8'hFF, 8'h00, 1'b1, 1'b0);
        run_add(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_add(8'h00, 8'h00, 1'b0, 1'b0);

        // Start held high: a done pulse every W+1 cycles.
        drive_start(8'h11, 8'h22, 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            wait_result(1);
            if (n < 3) drive_start(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end
        start = 1'b0;
        @(negedge clk);
        chk("stream_end_busy", 32'(busy), 32'd0);

        // Reset mid-operation aborts and clears outputs at once.
        drive_start(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        held_sum  = '0;
        held_cout = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(busy), 32'd0);
        run_add(8'h01, 8'h01, 1'b0, 1'b0);

`ifdef SERIAL_SUB_EN
        run_add(8'h50, 8'h20, 1'b0, 1'b1);
        run_add(8'h20, 8'h50, 1'b1, 1'b1);
        run_add(8'h33, 8'h33, 1'b0, 1'b1);
`endif

        // Random operand sets.
        for (int n = 0; n < 200; n++) begin
`ifdef SERIAL_SUB_EN
            run_add(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
            run_add(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
